// File: rtl/vga_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_reader
// Purpose  : 640x480@60 VGA timing from a divide-by-2 pixel tick; fetches a
//            200x200 RGB332 frame buffer and expands it to 8 bits per channel.
// Revision : 1.0
// ============================================================================
module vga_frame_reader #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int IMG_W  = 200,
  parameter int IMG_H  = 200,
  parameter logic [7:0] BORDER = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pix_data,
  output logic [15:0] pix_addr,
  output logic        h_sync,
  output logic        v_sync,
  output logic        blank_n,
  output logic        visible,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        frame_start
);

  localparam int c_hTot = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int c_vTot = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int c_hW   = $clog2(c_hTot);
  localparam int c_vW   = $clog2(c_vTot);

  localparam logic [c_hW-1:0] c_hLast      = c_hW'(c_hTot - 1);
  localparam logic [c_hW-1:0] c_hVis       = c_hW'(H_VIS);
  localparam logic [c_hW-1:0] c_hSyncStart = c_hW'(H_VIS + H_FP);
  localparam logic [c_hW-1:0] c_hSyncEnd   = c_hW'(H_VIS + H_FP + H_SYNC);
  localparam logic [c_hW-1:0] c_imgW       = c_hW'(IMG_W);
  localparam logic [c_vW-1:0] c_vLast      = c_vW'(c_vTot - 1);
  localparam logic [c_vW-1:0] c_vVis       = c_vW'(V_VIS);
  localparam logic [c_vW-1:0] c_vSyncStart = c_vW'(V_VIS + V_FP);
  localparam logic [c_vW-1:0] c_vSyncEnd   = c_vW'(V_VIS + V_FP + V_SYNC);
  localparam logic [c_vW-1:0] c_imgH       = c_vW'(IMG_H);

  logic            r_toggle;
  logic [c_hW-1:0] r_hCnt;
  logic [c_vW-1:0] r_vCnt;

  logic            r_hSync;
  logic            r_vSync;
  logic            r_blankN;
  logic            r_visible;
  logic [7:0]      r_red;
  logic [7:0]      r_green;
  logic [7:0]      r_blue;
  logic            r_frameStart;

  logic            w_tick;
  logic            w_inWin;
  logic            w_blankN;
  logic            w_hSyncAct;
  logic            w_vSyncAct;
  logic [15:0]     w_addrLin;
  logic [7:0]      w_src;

  assign w_tick     = r_toggle;
  assign w_inWin    = (r_hCnt < c_imgW) && (r_vCnt < c_imgH);
  assign w_blankN   = (r_hCnt < c_hVis) && (r_vCnt < c_vVis);
  assign w_hSyncAct = (r_hCnt >= c_hSyncStart) && (r_hCnt < c_hSyncEnd);
  assign w_vSyncAct = (r_vCnt >= c_vSyncStart) && (r_vCnt < c_vSyncEnd);

  // Linear frame-buffer address, intentionally truncated to 16 bits.
  assign w_addrLin  = 16'(r_vCnt) * 16'(IMG_W) + 16'(r_hCnt);
  assign pix_addr   = w_inWin ? w_addrLin : 16'hFFFF;

  always_comb begin
    w_src = 8'h00;
    if (w_blankN) begin
      w_src = w_inWin ? pix_data : BORDER;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_toggle <= 1'b0;
      r_hCnt   <= '0;
      r_vCnt   <= '0;
    end else begin
      r_toggle <= ~r_toggle;
      if (w_tick) begin
        if (r_hCnt == c_hLast) begin
          r_hCnt <= '0;
          r_vCnt <= (r_vCnt == c_vLast) ? '0 : r_vCnt + c_vW'(1);
        end else begin
          r_hCnt <= r_hCnt + c_hW'(1);
        end
      end
    end
  end

  // Output stage samples the pre-advance counters, so it trails them by one pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hSync      <= 1'b1;
      r_vSync      <= 1'b1;
      r_blankN     <= 1'b0;
      r_visible    <= 1'b0;
      r_red        <= 8'h00;
      r_green      <= 8'h00;
      r_blue       <= 8'h00;
      r_frameStart <= 1'b0;
    end else begin
      r_frameStart <= w_tick && (r_hCnt == '0) && (r_vCnt == '0);
      if (w_tick) begin
        r_hSync   <= ~w_hSyncAct;
        r_vSync   <= ~w_vSyncAct;
        r_blankN  <= w_blankN;
        r_visible <= w_inWin;
        r_red     <= {w_src[7:5], w_src[7:5], w_src[7:6]};
        r_green   <= {w_src[4:2], w_src[4:2], w_src[4:3]};
        r_blue    <= {4{w_src[1:0]}};
      end
    end
  end

  assign h_sync      = r_hSync;
  assign v_sync      = r_vSync;
  assign blank_n     = r_blankN;
  assign visible     = r_visible;
  assign red         = r_red;
  assign green       = r_green;
  assign blue        = r_blue;
  assign frame_start = r_frameStart;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_frame_reader
// Purpose  : Randomised frame-buffer bench for vga_frame_reader on a reduced
//            raster, with a queue-based scoreboard fed by a pixel-index model.
// Revision : 1.0
// ============================================================================
module tb_vga_frame_reader;

  localparam int H_VIS  = 40;
  localparam int H_FP   = 4;
  localparam int H_SYNC = 8;
  localparam int H_BP   = 6;
  localparam int V_VIS  = 24;
  localparam int V_FP   = 2;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 3;
  localparam int IMG_W  = 20;
  localparam int IMG_H  = 12;
  localparam logic [7:0] BORDER = 8'h6D;

  localparam int H_TOT     = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT     = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME_PIX = H_TOT * V_TOT;
  localparam int MEM_SIZE  = IMG_W * IMG_H;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  pix_data;
  logic [15:0] pix_addr;
  logic        h_sync, v_sync, blank_n, visible, frame_start;
  logic [7:0]  red, green, blue;

  vga_frame_reader #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .IMG_W(IMG_W), .IMG_H(IMG_H), .BORDER(BORDER)
  ) dut (
    .clk(clk), .reset(reset), .pix_data(pix_data), .pix_addr(pix_addr),
    .h_sync(h_sync), .v_sync(v_sync), .blank_n(blank_n), .visible(visible),
    .red(red), .green(green), .blue(blue), .frame_start(frame_start)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        hs, vs, bl, vis, fs;
    logic [7:0]  r, g, b;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mem [MEM_SIZE];
  int          checks = 0;
  int          failures = 0;

  logic [44:0] obs;
  assign obs = {pix_addr, h_sync, v_sync, blank_n, visible, frame_start, red, green, blue};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic checkReset(input string name);
    chk(name, 64'(obs), 64'({16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0}));
  endtask

  // Expected outputs for raster position outIdx, plus the address for addrIdx.
  function automatic exp_t modelPixel(int outIdx, int addrIdx);
    exp_t e;
    int x, y, ax, ay, src, cr, cg, cb;
    x = outIdx % H_TOT;
    y = (outIdx / H_TOT) % V_TOT;
    e.hs  = !(x >= H_VIS + H_FP && x < H_VIS + H_FP + H_SYNC);
    e.vs  = !(y >= V_VIS + V_FP && y < V_VIS + V_FP + V_SYNC);
    e.bl  = (x < H_VIS) && (y < V_VIS);
    e.vis = (x < IMG_W) && (y < IMG_H);
    e.fs  = (x == 0) && (y == 0);
    if (!e.bl)      src = 0;
    else if (e.vis) src = int'(mem[y * IMG_W + x]);
    else            src = int'(BORDER);
    cr = src / 32;
    cg = (src / 4) % 8;
    cb = src % 4;
    e.r = 8'(cr * 36 + cr / 2);
    e.g = 8'(cg * 36 + cg / 2);
    e.b = 8'(cb * 85);
    ax = addrIdx % H_TOT;
    ay = (addrIdx / H_TOT) % V_TOT;
    e.addr = (ax < IMG_W && ay < IMG_H) ? 16'(ay * IMG_W + ax) : 16'hFFFF;
    return e;
  endfunction

  // Memory with one clock of read latency; random junk outside the image.
  logic [15:0] memAddr;
  initial begin
    pix_data = 8'h00;
    forever begin
      @(negedge clk);
      memAddr = pix_addr;
      @(posedge clk);
      #2;
      pix_data = (int'(memAddr) < MEM_SIZE) ? mem[memAddr] : 8'($urandom);
    end
  end

  // Monitor: every output pixel is popped and compared on the negedge after its tick.
  exp_t mExp;
  int   cyc = 0;
  int   hsRun = 0;
  int   vsRun = 0;
  int   lastFs = -1;
  always @(negedge clk) begin
    if (reset) begin
      hsRun  = 0;
      vsRun  = 0;
      lastFs = -1;
    end else begin
      cyc++;
      if (q.size() > 0) begin
        mExp = q.pop_front();
        chk($sformatf("pixel@cyc%0d", cyc), 64'(obs),
            64'({mExp.addr, mExp.hs, mExp.vs, mExp.bl, mExp.vis, mExp.fs, mExp.r, mExp.g, mExp.b}));
      end else begin
        chk("frame_start_width", 64'(frame_start), 64'(0));
      end
      if (!h_sync) hsRun++;
      else if (hsRun > 0) begin
        chk("hsync_low_clks", 64'(hsRun), 64'(2 * H_SYNC));
        hsRun = 0;
      end
      if (!v_sync) vsRun++;
      else if (vsRun > 0) begin
        chk("vsync_low_clks", 64'(vsRun), 64'(2 * V_SYNC * H_TOT));
        vsRun = 0;
      end
      if (frame_start) begin
        if (lastFs >= 0) chk("frame_period", 64'(cyc - lastFs), 64'(2 * FRAME_PIX));
        lastFs = cyc;
      end
    end
  end

  // Runs from reset release; stops after nPix pixels, or resets asynchronously
  // just after the counters reach pixel resetAt.
  task automatic runPixels(input int nPix, input int resetAt);
    int e;
    int p;
    e = 0;
    forever begin
      @(posedge clk);
      #1;
      e++;
      if (e == 1) chk("first_tick_pending", 64'({blank_n, frame_start}), 64'(0));
      if (e % 2 == 0) begin
        p = e / 2;
        if (p == resetAt) begin
          #4;
          reset = 1'b1;
          #1;
          checkReset("async_reset_immediate");
          repeat (3) @(posedge clk);
          @(negedge clk);
          checkReset("async_reset_hold");
          reset = 1'b0;
          return;
        end
        q.push_back(modelPixel((p - 1) % FRAME_PIX, p % FRAME_PIX));
        if (p == nPix) return;
      end
    end
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 8'($urandom);
    mem[0] = 8'hE0;
    mem[1] = 8'h1C;
    mem[2] = 8'h03;
    mem[3] = 8'hFF;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkReset("reset_hold");
    reset = 1'b0;
    runPixels(0, 2 * FRAME_PIX + 10 * H_TOT + 30);
    runPixels(FRAME_PIX + 60, -1);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Downstream consumer of the Memory stage's VGA read port.
- Generates 640x480@60 VGA timing from the 50 MHz core clock using an internal divide-by-2 pixel tick.
- Issues pixel addresses for a 200x200 frame buffer and expands the returned RGB332 byte to 8-bit-per-channel colour.
- Drives sync, blank and colour outputs with all signals aligned to the same pixel.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- IMG_W, 200, frame-buffer width in pixels
- IMG_H, 200, frame-buffer height in pixels
- BORDER, 8'h00, RGB332 colour for visible pixels outside the image window

Ports:
- clk, in, 1, 50 MHz core clock
- reset, in, 1, asynchronous active-high reset
- pix_data, in, 8, RGB332 byte from memory: [7:5]=R, [4:2]=G, [1:0]=B; valid 1 clk after pix_addr changes
- pix_addr, out, 16, frame-buffer read address; 16'hFFFF outside the image window
- h_sync, out, 1, horizontal sync, active low
- v_sync, out, 1, vertical sync, active low
- blank_n, out, 1, 1 during the visible 640x480 region
- visible, out, 1, 1 when the output pixel lies inside the IMG_W x IMG_H window
- red, out, 8, red channel
- green, out, 8, green channel
- blue, out, 8, blue channel
- frame_start, out, 1, 1-clk pulse at the start of each frame

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - h_cnt=0, v_cnt=0, tick toggle=0.
  - h_sync=1, v_sync=1, blank_n=0, visible=0, red/green/blue=0, frame_start=0.
  - pix_addr=0, since it is combinational from counters at (0,0).
- Pixel tick: the toggle flips every clk, and tick = toggle==1. The first tick occurs on the 2nd rising edge after reset release. All counter and output registers update only on tick.
- Counters:
  - h_cnt runs 0..H_TOT-1, where H_TOT = H_VIS+H_FP+H_SYNC+H_BP = 800.
  - At a tick with h_cnt=H_TOT-1, h_cnt wraps to 0 and v_cnt increments.
  - v_cnt runs 0..V_TOT-1 (V_TOT=525); it wraps to 0 when h_cnt and v_cnt are both at their last value at the same tick.
- Address, combinational from the counters:
  - If h_cnt<IMG_W and v_cnt<IMG_H, pix_addr = v_cnt*IMG_W + h_cnt, truncated to 16 bits (max 39999).
  - Otherwise pix_addr = 16'hFFFF.
  - pix_addr is held for 2 clk per pixel; memory has 1 clk of read latency, so pix_data is stable before the next tick.
- Output stage, registered on tick using the counters' pre-advance value (output lags counters by exactly 1 pixel = 2 clk):
  - h_sync = ~(h_cnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1]), i.e. low for 656..751.
  - v_sync = ~(v_cnt in [490, 491]).
  - blank_n = h_cnt<H_VIS && v_cnt<V_VIS.
  - visible = in-window flag.
  - Colour source byte: pix_data if visible; BORDER if blank_n but not visible; forced to 0 when blank_n=0.
  - Colour expansion: red = {R,R,R[2:1]}, green = {G,G,G[2:1]}, blue = {B,B,B,B}.
- frame_start: asserted for exactly 1 clk, on the tick that loads the output registers for pixel (0,0). Period is 800*525*2 = 840000 clk.
- Reset mid-frame: all state returns to reset values immediately; the next frame restarts at (0,0) with no partial-line output.
- pix_data is sampled only on ticks; changes on non-tick cycles are ignored.

Test Plan:
- Reset, hold 5 clk, release:
  - Outputs hold their reset values and pix_addr=0.
  - The first tick occurs at the 2nd edge after release.
  - frame_start pulses with blank_n=1 on that tick.
- Run 1 line with pix_data=8'hE0:
  - For the first 200 output pixels: red=8'hFF, green=0, blue=0, visible=1.
  - Output pixels 200..639: BORDER colour 0, visible=0, blank_n=1.
  - blank_n=0 from output pixel 640.
- Check h_sync edges: low for exactly 96 pixels (192 clk), starting at output pixel 656, i.e. 2 clk after h_cnt=656.
- Address boundaries:
  - At (h_cnt,v_cnt)=(199,199), pix_addr=39999.
  - At (200,0) and (0,200), pix_addr=16'hFFFF.
  - At (5,1), pix_addr=205.
- Frame timing:
  - Two consecutive frame_start pulses are 840000 clk apart.
  - v_sync is low for 2 lines (3200 clk).
- Assert reset asynchronously mid-line at h_cnt=300, v_cnt=100:
  - Outputs return to reset values without waiting for clk.
  - After release, the counters restart from (0,0).
